add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor for the Pipelined_CPU execute path.
- Splits a WIDTH-bit ripple chain into STAGES registered slices, so long datapaths close timing at one result per cycle.
- Adds carry-chained modes (ADC/SBC), a valid/ready handshake with backpressure, a synchronous flush, and NZCV flags aligned with the result.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; also the latency in cycles; 1..WIDTH.

Ports:
- clk  input  1  clock; rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; kills all in-flight operations.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- cin  input  1  carry input; used by ADC/SBC only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_o  output  1  C flag.
- overflow_o  output  1  V flag.
- negative_o  output  1  N flag.
- zero_o  output  1  Z flag.

Behaviour:
- Reset: one clock `clk`; `reset_n` is asynchronous, active-low.
  - On assertion, all stage valids, out_valid, sum and all flags go to 0.
  - In-flight operations are dropped and not replayed.
- Arithmetic: result = a + (b or ~b) + cin_eff.
  - b is inverted for SUB and SBC.
  - cin_eff = 0 for ADD, 1 for SUB, cin for ADC/SBC.
- Slicing: SLICE = WIDTH/STAGES.
  - Stage k adds bits [k*SLICE +: SLICE] using the registered carry from stage k-1.
  - Unprocessed operand slices and finished sum slices travel skewed in registers, so all bits of one beat exit together.
- Flags, all computed on the full result of the same beat:
  - carry_o = carry out of bit WIDTH-1 (ARM no-borrow convention: SUB 0-0 gives C=1).
  - overflow_o = carry into bit WIDTH-1 XOR carry_o.
  - negative_o = sum[WIDTH-1].
  - zero_o = 1 when sum == 0. Each stage ANDs its slice-zero into a running zero bit.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, assuming no stall.
- Throughput: one beat per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stages shift only on advance.
  - Accept occurs when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - On stall, sum and flags hold stable.
  - Bubbles propagate as invalid stages; they are not collapsed.
- Simultaneous output transfer and new input accept in the same cycle is legal.
- Ordering is strictly FIFO; no beat is lost or duplicated under any out_ready pattern.
- flush:
  - Clears all stage valids and out_valid at the next edge.
  - in_ready is forced 0 during the flush cycle.
  - Data registers may keep stale values.
  - flush has priority over accept.
- in_valid held high while in_ready=0 causes no accept. Operands must be held by the source (standard valid/ready).
- STAGES=1: a single registered full-width adder, latency 1.

Optional Feature:
- Macro: ADD_SUB_PIPE_SAT_EN.
- Defined:
  - Adds input port `sat` (1 bit), sampled with the beat.
  - When sat=1 and signed overflow occurs, sum clamps to the most-positive (positive overflow) or most-negative (negative overflow) signed value.
  - overflow_o still reports 1.
  - negative_o and zero_o reflect the clamped sum; carry_o is unchanged.
- Undefined:
  - No `sat` port.
  - Results always wrap modulo 2^WIDTH.

Test Plan:
1. ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 4 cycles later: sum=0, C=1, Z=1, V=0, N=0.
2. SUB a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> sum=0x8000_0000_0000_0000, V=1, N=1, C=0, Z=0.
3. SUB 0-0 -> sum=0, C=1, V=0, Z=1. Then SBC 5-3 with cin=0 -> sum=1, C=1. Then ADC 2+3 with cin=1 -> sum=6, C=0.
4. Stream 8 back-to-back beats (a=i, b=i, ADD), out_ready=0 for cycles 5..7 -> in_ready=0 while stalled; outputs 0,2,4,...,14 in order; output held stable during the stall.
5. Assert reset_n=0 with 3 beats in flight -> out_valid=0 immediately, all outputs 0, no stale beat after release. Repeat with flush=1 -> same drop at the next edge.
6. With ADD_SUB_PIPE_SAT_EN defined, sat=1: 0x7FFF_FFFF_FFFF_FFFF + 1 -> sum=0x7FFF_FFFF_FFFF_FFFF, V=1, N=0. Same stimulus with sat=0 -> sum=0x8000_0000_0000_0000.

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// Operand/result valid-ready bundle for add_sub_pipe.
// Defining ADD_SUB_PIPE_SAT_EN adds the per-beat sat request bit.
interface add_sub_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_o;
    logic             overflow_o;
    logic             negative_o;
    logic             zero_o;

`ifdef ADD_SUB_PIPE_SAT_EN
    logic             sat;

    modport master (
        output in_valid, a, b, op, cin, sat, out_ready,
        input  in_ready, out_valid, sum, carry_o, overflow_o, negative_o, zero_o
    );

    modport slave (
        input  in_valid, a, b, op, cin, sat, out_ready,
        output in_ready, out_valid, sum, carry_o, overflow_o, negative_o, zero_o
    );
`else
    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, carry_o, overflow_o, negative_o, zero_o
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, carry_o, overflow_o, negative_o, zero_o
    );
`endif
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined ADD/SUB/ADC/SBC unit: STAGES ripple slices with skewed operands and NZCV flags.
// Optional signed saturation is enabled by defining ADD_SUB_PIPE_SAT_EN.
module add_sub_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    add_sub_pipe_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    logic             advance;
    logic             accept;
    logic             cin_eff;
    logic [WIDTH-1:0] b_eff;
    logic             last_ovf_d;
    logic             ovf_q;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // op[0] selects subtraction (b inverted), op[1] selects the external carry
    assign b_eff   = bus.op[0] ? ~bus.b : bus.b;
    assign cin_eff = bus.op[1] ? bus.cin : bus.op[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;
        localparam int HI  = LO + SLICE;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             z_in;
        logic             v_in;
`ifdef ADD_SUB_PIPE_SAT_EN
        logic             sat_in;
`endif
        logic [SLICE:0]   slice_res;
        logic             z_next;
        logic [HI-1:0]    s_next;
        logic [HI-1:0]    s_d;
        logic             z_d;

        logic             v_q;
        logic             c_q;
        logic             z_q;
        logic [HI-1:0]    s_q;

        if (k == 0) begin : g_first
            assign a_in   = bus.a;
            assign b_in   = b_eff;
            assign c_in   = cin_eff;
            assign z_in   = 1'b1;
            assign v_in   = accept;
`ifdef ADD_SUB_PIPE_SAT_EN
            assign sat_in = bus.sat;
`endif
            assign s_next = slice_res[SLICE-1:0];
        end else begin : g_next
            // Operand bits not yet summed, carried alongside the beat
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= g_stage[k-1].a_in[REM+SLICE-1:SLICE];
                    b_q <= g_stage[k-1].b_in[REM+SLICE-1:SLICE];
                end
            end

`ifdef ADD_SUB_PIPE_SAT_EN
            logic sat_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sat_q <= 1'b0;
                end else if (advance) begin
                    sat_q <= g_stage[k-1].sat_in;
                end
            end

            assign sat_in = sat_q;
`endif
            assign a_in   = a_q;
            assign b_in   = b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign z_in   = g_stage[k-1].z_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {slice_res[SLICE-1:0], g_stage[k-1].s_q};
        end

        assign slice_res = {1'b0, a_in[SLICE-1:0]} + {1'b0, b_in[SLICE-1:0]}
                         + {{SLICE{1'b0}}, c_in};
        assign z_next    = z_in && (slice_res[SLICE-1:0] == '0);

        if (k == STAGES - 1) begin : g_last
            logic a_msb;
            logic b_msb;
            logic ovf;
            logic clamp;

            assign a_msb = a_in[SLICE-1];
            assign b_msb = b_in[SLICE-1];
            // Same-sign operands producing an opposite-sign result is signed overflow
            assign ovf   = (a_msb == b_msb) && (slice_res[SLICE-1] != a_msb);
`ifdef ADD_SUB_PIPE_SAT_EN
            assign clamp = sat_in && ovf;
`else
            assign clamp = 1'b0;
`endif
            assign s_d        = clamp ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}})
                                      : s_next;
            assign z_d        = z_next && !clamp;
            assign last_ovf_d = ovf;
        end else begin : g_mid
            assign s_d = s_next;
            assign z_d = z_next;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                z_q <= 1'b0;
                s_q <= '0;
            end else begin
                if (flush) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_in;
                end
                if (advance) begin
                    c_q <= slice_res[SLICE];
                    z_q <= z_d;
                    s_q <= s_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= last_ovf_d;
        end
    end

    assign bus.out_valid  = g_stage[STAGES-1].v_q;
    assign bus.sum        = g_stage[STAGES-1].s_q;
    assign bus.carry_o    = g_stage[STAGES-1].c_q;
    assign bus.zero_o     = g_stage[STAGES-1].z_q;
    assign bus.negative_o = g_stage[STAGES-1].s_q[WIDTH-1];
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: a reference model queues expected results per accepted beat,
// a negedge monitor pops and compares them on every output transfer.
module tb_add_sub_pipe;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
`ifdef ADD_SUB_PIPE_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic randomReady = 1'b0;
    logic rndReady    = 1'b1;
    logic readyForce  = 1'b1;

    int checkCount = 0;
    int passCount  = 0;

    logic [WIDTH+3:0] sb[$];

    add_sub_pipe_if #(.WIDTH(WIDTH)) bus ();

    add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = randomReady ? rndReady : readyForce;

    always @(posedge clk) begin
        #1;
        rndReady = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: full-width sum plus a separate (WIDTH-1)-bit add for the carry into the MSB
    function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [1:0] o, input logic ci, input logic s);
        logic [WIDTH-1:0] yy;
        logic             c0;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        yy = (o == OP_SUB || o == OP_SBC) ? ~y : y;
        case (o)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            default: c0 = ci;
        endcase
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
        low  = {1'b0, x[WIDTH-2:0]} + {1'b0, yy[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c0};
        r = full[WIDTH-1:0];
        c = full[WIDTH];
        v = low[WIDTH-1] ^ c;
        if (SAT_BUILD && s && v) begin
            r = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {r, c, v, r[WIDTH-1], (r == '0)};
    endfunction

    function automatic logic [WIDTH-1:0] flagsObs();
        return {{(WIDTH-4){1'b0}}, bus.carry_o, bus.overflow_o, bus.negative_o, bus.zero_o};
    endfunction

    always @(negedge clk) begin
        if (reset_n && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_beat", WIDTH'(bus.out_valid), '0);
            end else begin
                logic [WIDTH+3:0] expBeat;
                expBeat = sb.pop_front();
                checkOutput("sum", bus.sum, expBeat[WIDTH+3:4]);
                checkOutput("flags_CVNZ", flagsObs(), {{(WIDTH-4){1'b0}}, expBeat[3:0]});
            end
        end
    end

    // Presents one beat, holds it until in_ready is seen, then queues its expected result
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic [1:0] opCode, input logic carryIn, input logic satIn);
        logic taken;
        int   budget;
        bus.a   = opA;
        bus.b   = opB;
        bus.op  = opCode;
        bus.cin = carryIn;
`ifdef ADD_SUB_PIPE_SAT_EN
        bus.sat = satIn;
`endif
        bus.in_valid = 1'b1;
        taken  = 1'b0;
        budget = 0;
        while (!taken && budget < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                taken = 1'b1;
                sb.push_back(model(opA, opB, opCode, carryIn, satIn));
            end
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (!taken) checkOutput("accept_timeout", WIDTH'(taken), WIDTH'(1));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput(tag, WIDTH'(sb.size()), '0);
    endtask

    task automatic countStray(input string tag);
        int stray;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        checkOutput(tag, WIDTH'(stray), '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [WIDTH-1:0] held;
        reset_n      = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.op       = OP_ADD;
        bus.cin      = 1'b0;
`ifdef ADD_SUB_PIPE_SAT_EN
        bus.sat      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", WIDTH'(bus.out_valid), '0);
        checkOutput("reset_sum", bus.sum, '0);
        checkOutput("reset_flags", flagsObs(), '0);
        reset_n = 1'b1;
        idleCycles(1);

        $display("[TB] carry-out wrap and latency");
        applyStimulus({WIDTH{1'b1}}, 64'd1, OP_ADD, 1'b0, 1'b0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", WIDTH'(n), WIDTH'(STAGES));
        waitDrain("drain_add_wrap");

        $display("[TB] signed overflow, borrow conventions, carry modes");
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SUB, 1'b0, 1'b0);
        applyStimulus(64'd0, 64'd0, OP_SUB, 1'b0, 1'b0);
        applyStimulus(64'd5, 64'd3, OP_SBC, 1'b0, 1'b0);
        applyStimulus(64'd2, 64'd3, OP_ADC, 1'b1, 1'b0);
        applyStimulus(64'd5, 64'd3, OP_ADD, 1'b1, 1'b0);
        applyStimulus(64'd3, 64'd5, OP_SUB, 1'b0, 1'b0);
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, OP_ADD, 1'b0, 1'b0);
        waitDrain("drain_directed");

        $display("[TB] back-to-back stream with output stall");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(WIDTH'(i), WIDTH'(i), OP_ADD, 1'b0, 1'b0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                readyForce = 1'b0;
                held = '0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", WIDTH'(bus.in_ready), '0);
                    checkOutput("stall_out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
                    if (i == 0) held = bus.sum;
                    else checkOutput("stall_hold", bus.sum, held);
                end
                @(posedge clk);
                #1;
                readyForce = 1'b1;
            end
        join
        waitDrain("drain_stream");

        $display("[TB] asynchronous reset with beats in flight");
        readyForce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(WIDTH'(100 + i), 64'd7, OP_ADD, 1'b0, 1'b0);
        end
        idleCycles(2);
        checkOutput("pre_reset_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", WIDTH'(bus.out_valid), '0);
        checkOutput("async_reset_sum", bus.sum, '0);
        checkOutput("async_reset_flags", flagsObs(), '0);
        sb.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        readyForce = 1'b1;
        countStray("stray_after_reset");

        $display("[TB] flush with beats in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(WIDTH'(200 + i), 64'd9, OP_SUB, 1'b0, 1'b0);
        end
        flush        = 1'b1;
        bus.a        = 64'd77;
        bus.b        = 64'd1;
        bus.op       = OP_ADD;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", WIDTH'(bus.in_ready), '0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        countStray("stray_after_flush");
        applyStimulus(64'd40, 64'd2, OP_ADD, 1'b0, 1'b0);
        waitDrain("drain_after_flush");

        $display("[TB] saturation request (wraps when the option is absent)");
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 1'b0, 1'b1);
        waitDrain("drain_sat");

        $display("[TB] random beats under random backpressure");
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end
        randomReady = 1'b0;
        readyForce  = 1'b1;
        waitDrain("drain_random");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
